rv32i_dmem_ctrl: RTL and testbench
==================================

# rv32i_dmem_ctrl

Data-side memory controller directly downstream of the pipelined rv32i CPU's memory stage. Consumes the CPU's M-stage store/address bus (MemWriteM, ALUResult, WriteData, Byte_Enable) and returns ReadData with one-cycle synchronous latency, matching the CPU's synchronous-memory timing. Decodes the address into a byte-writable data RAM and a small peripheral window: a 64-bit cycle counter and a buffered byte-stream TX port with a valid/ready handshake.

## Interface
- DMEM_WORDS, 1024, data RAM depth in 32-bit words (power of two).
- DMEM_BASE, 32'h2000_0000, RAM base address; RAM spans DMEM_BASE .. DMEM_BASE + 4*DMEM_WORDS - 1.
- PERIPH_BASE, 32'h4000_0000, peripheral window base; window is 256 bytes.
- TX_DEPTH, 4, TX FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- n_rst  in  1  reset; synchronous, active-high (1 = reset).
- MemWriteM  in  1  store strobe for the current cycle.
- ALUResult  in  32  byte address; bits [1:0] ignored (word access).
- WriteData  in  32  store data, already lane-aligned by the datapath.
- Byte_Enable  in  4  bit i enables byte lane i (WriteData[8i+7:8i]).
- ReadData  out  32  full word at the previous cycle's address.
- tx_valid  out  1  TX FIFO head is valid.
- tx_data  out  8  TX FIFO head byte.
- tx_ready  in  1  sink accepts tx_data this cycle.

## Operation
- Reads carry no strobe: every cycle the word at ALUResult is looked up and registered into ReadData. Reads have no side effects.
- RAM: on MemWriteM=1 and address in range, each enabled byte lane is written. RAM contents are not reset.
- Peripheral registers at PERIPH_BASE offsets:
  - 0x00 CYCLE_LO (RO): counter[31:0].
  - 0x04 CYCLE_HI (RO): counter[63:32]. LO/HI reads are not atomic; software re-reads HI.
  - 0x10 TX_DATA (WO): store with Byte_Enable[0]=1 pushes WriteData[7:0]. Reads return 0.
  - 0x14 TX_STATUS: bit0 full, bit1 empty, bits[4:2] count (zero-extended; saturates the field for TX_DEPTH>7), bit8 overflow (sticky). Store with Byte_Enable[1]=1 and WriteData[8]=1 clears overflow (W1C). Other bits read 0, writes ignored.
- Unmapped addresses: reads return 32'h0, stores ignored.
- Stores to RO registers are ignored.
- Cycle counter: 64-bit, +1 every cycle, wraps 2^64-1 → 0.
- TX FIFO:
  - Pop when tx_valid & tx_ready.
  - Push when TX_DATA store and (not full, or pop same cycle).
  - Full with no pop: push dropped, overflow set.
  - Overflow set and W1C clear in the same cycle: set wins.
  - tx_data is stable while tx_valid=1 and tx_ready=0.

## Timing
- Reset values: ReadData 0, tx_valid 0, tx_data 0, FIFO empty (count 0), counter 0, overflow 0.
- Read latency is 1 cycle: address at edge N → ReadData valid after edge N+1.
- A store cycle returns read-before-write data: ReadData next cycle holds the old word. The new value is visible from the following access.
- Status reads reflect state before the current edge's push/pop.
- Pushed byte: tx_valid rises the cycle after the push edge. FIFO is first-word-fall-through from storage.
- Simultaneous push and pop: count unchanged, order preserved, legal when full or non-empty. Push to empty with pop impossible (tx_valid=0).
- Reset mid-operation: FIFO contents discarded, tx_valid drops the cycle after n_rst sampled high, in-flight store ignored. RAM is untouched.
- Pointers wrap modulo TX_DEPTH. Count is log2(TX_DEPTH)+1 bits.

## Structure
- Package rv32i_mem_pkg holds:
  - DMEM_BASE/PERIPH_BASE defaults.
  - Register offsets (OFS_CYCLE_LO, OFS_CYCLE_HI, OFS_TX_DATA, OFS_TX_STATUS).
  - Status bit positions (ST_FULL, ST_EMPTY, ST_COUNT_LSB, ST_OVF).
  - An address-region enum {REG_RAM, REG_PERIPH, REG_NONE}.
- Sub-module sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count) instantiated as u_tx_fifo.
- Top contains the decode, RAM array, counter, overflow flag and read mux/register.

## Test plan
- Reset, then read 0x4000_0000 on consecutive cycles → ReadData 0, then increments by the cycle spacing. ReadData, tx_valid and overflow are all 0 after reset.
- Store 0xDEADBEEF BE=4'b1111 to 0x2000_0010, then BE=4'b0010 data 0x0000_5500, then read → 0xDEAD55EF. Read issued in a store cycle returns the pre-store word.
- Hold tx_ready=0 and push 0x41,0x42,0x43,0x44, then 0x45 → STATUS = full, count 4, overflow=1. Release tx_ready → 0x41..0x44 in order, then empty.
- With FIFO full, tx_ready=1 and push 0x46 the same cycle → no overflow, count stays 4, 0x46 emitted last. W1C of overflow coincident with a dropped push → overflow remains 1.
- Read 0x3000_0000 → 0. Store there, then read RAM word 0 → unchanged.
- Assert n_rst with 3 bytes queued → tx_valid 0 next cycle, count 0. RAM word written before reset reads back unchanged.

Source files
------------

// File: rtl/rv32i_dmem_ctrl_pkg.sv
// ============================================================================
// Module   : rv32i_mem_pkg
// Brief    : Shared constants, register map and address-region decode for the
//            rv32i data-side memory controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_mem_pkg;

  // Default memory map
  localparam logic [31:0] DMEM_BASE_DEF   = 32'h2000_0000;
  localparam logic [31:0] PERIPH_BASE_DEF = 32'h4000_0000;
  localparam logic [31:0] PERIPH_BYTES    = 32'd256;

  // Peripheral register offsets (word aligned, relative to the window base)
  localparam logic [7:0] OFS_CYCLE_LO  = 8'h00;
  localparam logic [7:0] OFS_CYCLE_HI  = 8'h04;
  localparam logic [7:0] OFS_TX_DATA   = 8'h10;
  localparam logic [7:0] OFS_TX_STATUS = 8'h14;

  // TX_STATUS bit positions
  localparam int ST_FULL      = 0;
  localparam int ST_EMPTY     = 1;
  localparam int ST_COUNT_LSB = 2;
  localparam int ST_COUNT_W   = 3;
  localparam int ST_OVF       = 8;

  typedef enum logic [1:0] {
    REG_RAM    = 2'd0,
    REG_PERIPH = 2'd1,
    REG_NONE   = 2'd2
  } region_e;

  // Offset-from-base compare: unsigned wrap makes addresses below a base
  // land far outside the window, so one compare covers both bounds.
  function automatic region_e decode_region(
    input logic [31:0] addr,
    input logic [31:0] dmem_base,
    input logic [31:0] dmem_bytes,
    input logic [31:0] periph_base
  );
    logic [31:0] d_off;
    logic [31:0] p_off;
    region_e     r;
    d_off = addr - dmem_base;
    p_off = addr - periph_base;
    if (d_off < dmem_bytes) begin
      r = REG_RAM;
    end else if (p_off < PERIPH_BYTES) begin
      r = REG_PERIPH;
    end else begin
      r = REG_NONE;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv32i_dmem_ctrl_if.sv
// ============================================================================
// Module   : rv32i_dmem_ctrl_if
// Brief    : M-stage store/address bus plus TX byte-stream handshake between
//            the CPU/sink side (master) and the memory controller (slave).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rv32i_dmem_ctrl_if;
  logic        MemWriteM;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [3:0]  Byte_Enable;
  logic [31:0] ReadData;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output MemWriteM, ALUResult, WriteData, Byte_Enable, tx_ready,
    input  ReadData, tx_valid, tx_data
  );

  modport slave (
    input  MemWriteM, ALUResult, WriteData, Byte_Enable, tx_ready,
    output ReadData, tx_valid, tx_data
  );
endinterface

`default_nettype wire

// File: rtl/rv32i_dmem_ctrl_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock FIFO, head word falls through from storage.
//            A push while full is accepted only when a pop happens the same
//            cycle; a pop while empty is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full     = (cnt == CW'(DEPTH));
  assign empty    = (cnt == '0);
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  // Storage write; contents are don't-care until counted as valid
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at power-of-two depth
  always_ff @(posedge clk) begin
    if (n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv32i_dmem_ctrl.sv
// ============================================================================
// Module   : rv32i_dmem_ctrl
// Brief    : Data-side memory controller for the pipelined rv32i CPU.
//            Byte-writable RAM, 64-bit cycle counter and a buffered TX byte
//            port, all read back through a one-cycle registered ReadData.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rv32i_dmem_ctrl
  import rv32i_mem_pkg::*;
#(
  parameter int          DMEM_WORDS  = 1024,
  parameter logic [31:0] DMEM_BASE   = DMEM_BASE_DEF,
  parameter logic [31:0] PERIPH_BASE = PERIPH_BASE_DEF,
  parameter int          TX_DEPTH    = 4
) (
  input logic               clk,
  input logic               n_rst,
  rv32i_dmem_ctrl_if.slave  bus
);

  localparam int          AW         = $clog2(DMEM_WORDS);
  localparam int          CW         = $clog2(TX_DEPTH) + 1;
  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);

  logic [31:0]   mem [DMEM_WORDS];
  logic [63:0]   cycle_cnt;
  logic          tx_ovf;

  region_e       region;
  logic [7:0]    ofs;
  logic [AW-1:0] widx;
  logic          store;
  logic          ram_we;
  logic          tx_push_req;
  logic          ovf_clr;
  logic          ovf_set;
  logic          tx_pop;

  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [2:0]    cnt_field;
  logic [31:0]   status;
  logic [31:0]   rd_next;

  // Address decode and store qualification; stores during reset are dropped
  always_comb begin
    region      = decode_region(bus.ALUResult, DMEM_BASE, DMEM_BYTES, PERIPH_BASE);
    ofs         = 8'((bus.ALUResult - PERIPH_BASE) & 32'h0000_00FC);
    widx        = AW'((bus.ALUResult - DMEM_BASE) >> 2);
    store       = bus.MemWriteM && !n_rst;
    ram_we      = store && (region == REG_RAM);
    tx_push_req = store && (region == REG_PERIPH) && (ofs == OFS_TX_DATA)
                  && bus.Byte_Enable[0];
    ovf_clr     = store && (region == REG_PERIPH) && (ofs == OFS_TX_STATUS)
                  && bus.Byte_Enable[1] && bus.WriteData[ST_OVF];
    tx_pop      = !fifo_empty && bus.tx_ready;
    ovf_set     = tx_push_req && fifo_full && !tx_pop;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (tx_push_req),
    .push_data (bus.WriteData[7:0]),
    .pop       (tx_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_head;

  // The status count field is 3 bits wide; deeper FIFOs saturate it
  if (CW <= ST_COUNT_W) begin : g_cnt_zext
    assign cnt_field = 3'(fifo_count);
  end else begin : g_cnt_sat
    assign cnt_field = (fifo_count > CW'(7)) ? 3'd7 : fifo_count[2:0];
  end

  // Byte-lane RAM write; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.Byte_Enable[i]) begin
          mem[widx][8*i +: 8] <= bus.WriteData[8*i +: 8];
        end
      end
    end
  end

  // Free-running 64-bit cycle counter
  always_ff @(posedge clk) begin
    if (n_rst) begin
      cycle_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 64'd1;
    end
  end

  // Sticky TX overflow flag; a new overflow beats a coincident clear
  always_ff @(posedge clk) begin
    if (n_rst) begin
      tx_ovf <= 1'b0;
    end else if (ovf_set) begin
      tx_ovf <= 1'b1;
    end else if (ovf_clr) begin
      tx_ovf <= 1'b0;
    end
  end

  // Read mux over pre-edge state, giving read-before-write on store cycles
  always_comb begin
    status                                  = '0;
    status[ST_FULL]                         = fifo_full;
    status[ST_EMPTY]                        = fifo_empty;
    status[ST_COUNT_LSB +: ST_COUNT_W]      = cnt_field;
    status[ST_OVF]                          = tx_ovf;
    rd_next                                 = '0;
    case (region)
      REG_RAM: rd_next = mem[widx];
      REG_PERIPH: begin
        case (ofs)
          OFS_CYCLE_LO:  rd_next = cycle_cnt[31:0];
          OFS_CYCLE_HI:  rd_next = cycle_cnt[63:32];
          OFS_TX_STATUS: rd_next = status;
          default:       rd_next = '0;
        endcase
      end
      default: rd_next = '0;
    endcase
  end

  // One-cycle registered read return
  always_ff @(posedge clk) begin
    if (n_rst) begin
      bus.ReadData <= '0;
    end else begin
      bus.ReadData <= rd_next;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rv32i_dmem_ctrl.sv
// ============================================================================
// Module   : tb_rv32i_dmem_ctrl
// Brief    : Self-checking bench: directed scenarios with literal expectations
//            followed by randomized traffic against a queue/array model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rv32i_dmem_ctrl;

  localparam int          DMEM_WORDS = 1024;
  localparam int          TX_DEPTH   = 4;
  localparam logic [31:0] DB         = 32'h2000_0000;
  localparam logic [31:0] PB         = 32'h4000_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32i_dmem_ctrl_if bus ();

  rv32i_dmem_ctrl #(
    .DMEM_WORDS  (DMEM_WORDS),
    .DMEM_BASE   (DB),
    .PERIPH_BASE (PB),
    .TX_DEPTH    (TX_DEPTH)
  ) dut (
    .clk   (clk),
    .n_rst (rst),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0]    m_mem [DMEM_WORDS];
  bit             m_known [DMEM_WORDS];
  byte unsigned   m_q[$];
  longint unsigned m_cyc = 0;
  bit             m_ovf = 0;
  logic [31:0]    m_rd = 0;
  bit             m_rd_known = 0;
  bit             armed = 0;

  always @(posedge clk) begin : model
    logic [31:0] a, d_off, p_off, off, rd;
    bit          known, in_ram, in_per, pop, push_req;
    int          sz, idx;
    if (rst) begin
      m_rd = 0; m_rd_known = 1; m_q.delete(); m_cyc = 0; m_ovf = 0; armed = 1;
    end else begin
      a      = bus.ALUResult;
      d_off  = a - DB;
      p_off  = a - PB;
      in_ram = d_off < 32'(4 * DMEM_WORDS);
      in_per = !in_ram && (p_off < 32'd256);
      off    = p_off & 32'hFC;
      idx    = int'(d_off >> 2);
      sz     = m_q.size();
      rd = 0; known = 1;
      if (in_ram) begin
        if (m_known[idx]) rd = m_mem[idx]; else known = 0;
      end else if (in_per) begin
        if (off == 0)          rd = m_cyc[31:0];
        else if (off == 4)     rd = m_cyc[63:32];
        else if (off == 'h14) begin
          if (sz == TX_DEPTH) rd = rd | 32'h1;
          if (sz == 0)        rd = rd | 32'h2;
          rd = rd | (32'((sz > 7) ? 7 : sz) << 2);
          if (m_ovf)          rd = rd | 32'h100;
        end
      end
      m_rd = rd; m_rd_known = known;
      // state updates
      pop      = (sz > 0) && bus.tx_ready;
      push_req = bus.MemWriteM && in_per && (off == 'h10) && bus.Byte_Enable[0];
      if (push_req && sz == TX_DEPTH && !pop) m_ovf = 1;
      else if (bus.MemWriteM && in_per && off == 'h14 && bus.Byte_Enable[1] && bus.WriteData[8])
        m_ovf = 0;
      if (pop) void'(m_q.pop_front());
      if (push_req && (sz < TX_DEPTH || pop)) m_q.push_back(bus.WriteData[7:0]);
      if (bus.MemWriteM && in_ram) begin
        for (int i = 0; i < 4; i++)
          if (bus.Byte_Enable[i]) m_mem[idx][8*i +: 8] = bus.WriteData[8*i +: 8];
        if (bus.Byte_Enable == 4'hF) m_known[idx] = 1;
      end
      m_cyc++;
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (armed) begin
      if (m_rd_known) check("ReadData", bus.ReadData, m_rd);
      check("tx_valid", 32'(bus.tx_valid), 32'(m_q.size() > 0));
      check("tx_data", 32'(bus.tx_data), (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] be, input bit rdy);
    bus.MemWriteM   = we;
    bus.ALUResult   = addr;
    bus.WriteData   = wd;
    bus.Byte_Enable = be;
    bus.tx_ready    = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int offs[5];
    int kind, ready_bias;
    logic [31:0] addr;
    offs = '{0, 4, 8, 'h10, 'h14};

    bus.MemWriteM = 0; bus.ALUResult = 0; bus.WriteData = 0;
    bus.Byte_Enable = 0; bus.tx_ready = 0;
    rst = 1;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("rst_readdata", bus.ReadData, 32'h0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
    rst = 0;

    // cycle counter reads
    cyc(0, PB, 0, 0, 0);       check("cyc_lo_0", bus.ReadData, 32'd0);
    cyc(0, PB, 0, 0, 0);       check("cyc_lo_1", bus.ReadData, 32'd1);
    cyc(0, PB, 0, 0, 0);       check("cyc_lo_2", bus.ReadData, 32'd2);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, PB, 0, 0, 0);       check("cyc_lo_5", bus.ReadData, 32'd5);
    cyc(0, PB + 4, 0, 0, 0);   check("cyc_hi", bus.ReadData, 32'd0);
    cyc(0, PB + 'h14, 0, 0, 0); check("status_rst", bus.ReadData, 32'h2);

    // byte-lane store and read-before-write
    cyc(1, DB + 'h10, 32'hDEAD_BEEF, 4'b1111, 0);
    cyc(1, DB + 'h10, 32'h0000_5500, 4'b0010, 0);
    check("rbw_old_word", bus.ReadData, 32'hDEAD_BEEF);
    cyc(0, DB + 'h10, 0, 0, 0); check("byte_merge", bus.ReadData, 32'hDEAD_55EF);
    cyc(1, DB, 32'hCAFE_F00D, 4'hF, 0);

    // fill, overflow, drain
    for (int i = 0; i < 5; i++) cyc(1, PB + 'h10, 32'(8'h41 + i), 4'b0001, 0);
    cyc(0, PB + 'h14, 0, 0, 0); check("status_full_ovf", bus.ReadData, 32'h111);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 32'(bus.tx_data), 32'(8'h41 + i));
      cyc(0, DB, 0, 0, 1);
    end
    check("drain_empty", 32'(bus.tx_valid), 32'h0);
    cyc(1, PB + 'h14, 32'h100, 4'b0010, 0);
    cyc(0, PB + 'h14, 0, 0, 0); check("ovf_w1c", bus.ReadData, 32'h2);

    // push while full with simultaneous pop
    for (int i = 0; i < 4; i++) cyc(1, PB + 'h10, 32'(8'h41 + i), 4'b0001, 0);
    cyc(1, PB + 'h10, 32'h46, 4'b0001, 1);
    cyc(0, PB + 'h14, 0, 0, 0); check("full_push_pop", bus.ReadData, 32'h11);
    check("order_0", 32'(bus.tx_data), 32'h42); cyc(0, DB, 0, 0, 1);
    check("order_1", 32'(bus.tx_data), 32'h43); cyc(0, DB, 0, 0, 1);
    check("order_2", 32'(bus.tx_data), 32'h44); cyc(0, DB, 0, 0, 1);
    check("order_3", 32'(bus.tx_data), 32'h46); cyc(0, DB, 0, 0, 1);
    check("order_empty", 32'(bus.tx_valid), 32'h0);

    // unmapped region and RAM boundary
    cyc(0, 32'h3000_0000, 0, 0, 0); check("unmapped_rd", bus.ReadData, 32'h0);
    cyc(1, 32'h3000_0000, 32'h1234_5678, 4'hF, 0);
    cyc(0, DB, 0, 0, 0);            check("unmapped_wr", bus.ReadData, 32'hCAFE_F00D);
    cyc(1, DB + 'hFFC, 32'hA5A5_A5A5, 4'hF, 0);
    cyc(1, DB + 'h1000, 32'h5A5A_5A5A, 4'hF, 0);
    cyc(0, DB + 'hFFC, 0, 0, 0);    check("ram_top", bus.ReadData, 32'hA5A5_A5A5);
    cyc(0, DB + 'h1000, 0, 0, 0);   check("ram_past_end", bus.ReadData, 32'h0);
    cyc(0, DB, 0, 0, 0);            check("ram_no_alias", bus.ReadData, 32'hCAFE_F00D);

    // reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1, PB + 'h10, 32'(8'h61 + i), 4'b0001, 0);
    rst = 1;
    cyc(1, DB, 32'h1111_1111, 4'hF, 0);
    check("midrst_tx_valid", 32'(bus.tx_valid), 32'h0);
    rst = 0;
    cyc(0, PB + 'h14, 0, 0, 0); check("midrst_status", bus.ReadData, 32'h2);
    cyc(0, DB, 0, 0, 0);        check("midrst_ram", bus.ReadData, 32'hCAFE_F00D);

    // randomized traffic
    ready_bias = 1;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) ready_bias = $urandom_range(0, 3);
      kind = $urandom_range(0, 9);
      if (kind <= 3)
        addr = DB + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      else if (kind <= 7)
        addr = PB + 32'(offs[$urandom_range(0, 4)]) + 32'($urandom_range(0, 3));
      else if (kind == 8)
        addr = DB + 'hFFC;
      else
        case ($urandom_range(0, 3))
          0:       addr = DB + 'h1000;
          1:       addr = PB + 'h100;
          2:       addr = PB - 4;
          default: addr = 32'h3000_0000 + 32'($urandom_range(0, 255));
        endcase
      rst = ($urandom_range(0, 299) == 0);
      cyc($urandom_range(0, 1) == 1, addr, $urandom, 4'($urandom),
          $urandom_range(0, 3) < ready_bias);
    end
    rst = 0;
    cyc(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
